// File: rtl/qupls_div_arbiter_if.sv
// Request/result bundle between the two ALU issue slots and the shared divider.
interface qupls_div_arbiter_if #(
    parameter int unsigned WID    = 64,
    parameter int unsigned RNDX_W = 5
);
    logic              req0;
    logic [RNDX_W-1:0] req0_rndx;
    logic [WID-1:0]    req0_a;
    logic [WID-1:0]    req0_b;
    logic              req0_sgn;

    logic              req1;
    logic [RNDX_W-1:0] req1_rndx;
    logic [WID-1:0]    req1_a;
    logic [WID-1:0]    req1_b;
    logic              req1_sgn;

    logic              flush;

    logic              gnt0;
    logic              gnt1;
    logic              busy;
    logic              done_v;
    logic              done_src;
    logic [RNDX_W-1:0] done_rndx;
    logic [WID-1:0]    done_q;
    logic [WID-1:0]    done_r;
    logic              done_dbz;

    // Requester / scheduler side
    modport master (
        output req0, req0_rndx, req0_a, req0_b, req0_sgn,
        output req1, req1_rndx, req1_a, req1_b, req1_sgn,
        output flush,
        input  gnt0, gnt1, busy,
        input  done_v, done_src, done_rndx, done_q, done_r, done_dbz
    );

    // Divider side
    modport slave (
        input  req0, req0_rndx, req0_a, req0_b, req0_sgn,
        input  req1, req1_rndx, req1_a, req1_b, req1_sgn,
        input  flush,
        output gnt0, gnt1, busy,
        output done_v, done_src, done_rndx, done_q, done_r, done_dbz
    );
endinterface

// File: rtl/qupls_div_arbiter.sv
// Shared iterative radix-2 divider for two ALU slots: round-robin arbitration,
// restoring division on magnitudes, sign fix-up and ROB-tagged result.
module qupls_div_arbiter #(
    parameter int unsigned WID    = 64,
    parameter int unsigned RNDX_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    qupls_div_arbiter_if.slave bus
);
    localparam int unsigned      CNT_W    = (WID > 1) ? $clog2(WID) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WID - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              rr_q, rr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              src_q, src_d;
    logic [RNDX_W-1:0] rndx_q, rndx_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic              dbz_q, dbz_d;
    logic [WID-1:0]    dvd_q, dvd_d;
    logic [WID-1:0]    dvs_q, dvs_d;
    logic [WID-1:0]    rem_q, rem_d;

    logic              done_v_q, done_v_d;
    logic              done_src_q, done_src_d;
    logic [RNDX_W-1:0] done_rndx_q, done_rndx_d;
    logic [WID-1:0]    done_quo_q, done_quo_d;
    logic [WID-1:0]    done_rem_q, done_rem_d;
    logic              done_dbz_q, done_dbz_d;

    logic              idle_c;
    logic              win0_c, win1_c;
    logic              gnt0_c, gnt1_c, any_gnt_c;

    logic [RNDX_W-1:0] sel_rndx_c;
    logic [WID-1:0]    sel_a_c, sel_b_c;
    logic              sel_sgn_c;
    logic [WID-1:0]    mag_a_c, mag_b_c;

    logic [WID:0]      rem_sh_c, diff_c;
    logic              qbit_c;
    logic [WID-1:0]    quo_fix_c, rem_fix_c;

    // Round-robin grant: sole requester wins, on contention the rr pointer decides
    assign idle_c    = (state_q == IDLE);
    assign win0_c    = bus.req0 & (~bus.req1 | ~rr_q);
    assign win1_c    = bus.req1 & (~bus.req0 |  rr_q);
    assign gnt0_c    = idle_c & ~bus.flush & win0_c;
    assign gnt1_c    = idle_c & ~bus.flush & win1_c;
    assign any_gnt_c = gnt0_c | gnt1_c;

    // Winning request operands and their magnitudes for the unsigned core
    assign sel_rndx_c = gnt1_c ? bus.req1_rndx : bus.req0_rndx;
    assign sel_a_c    = gnt1_c ? bus.req1_a    : bus.req0_a;
    assign sel_b_c    = gnt1_c ? bus.req1_b    : bus.req0_b;
    assign sel_sgn_c  = gnt1_c ? bus.req1_sgn  : bus.req0_sgn;
    assign mag_a_c    = (sel_sgn_c & sel_a_c[WID-1]) ? (~sel_a_c + WID'(1)) : sel_a_c;
    assign mag_b_c    = (sel_sgn_c & sel_b_c[WID-1]) ? (~sel_b_c + WID'(1)) : sel_b_c;

    // One restoring step: shift in next dividend bit, subtract divisor if no borrow
    assign rem_sh_c = {rem_q, dvd_q[WID-1]};
    assign diff_c   = rem_sh_c - {1'b0, dvs_q};
    assign qbit_c   = ~diff_c[WID];

    // Sign correction of the magnitude results
    assign quo_fix_c = negq_q ? (~dvd_q + WID'(1)) : dvd_q;
    assign rem_fix_c = negr_q ? (~rem_q + WID'(1)) : rem_q;

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        rndx_d      = rndx_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        dbz_d       = dbz_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        done_v_d    = 1'b0;
        done_src_d  = done_src_q;
        done_rndx_d = done_rndx_q;
        done_quo_d  = done_quo_q;
        done_rem_d  = done_rem_q;
        done_dbz_d  = done_dbz_q;

        unique case (state_q)
            IDLE: begin
                if (any_gnt_c) begin
                    rr_d   = gnt0_c;
                    src_d  = gnt1_c;
                    rndx_d = sel_rndx_c;
                    negq_d = sel_sgn_c & (sel_a_c[WID-1] ^ sel_b_c[WID-1]);
                    negr_d = sel_sgn_c & sel_a_c[WID-1];
                    dvs_d  = mag_b_c;
                    rem_d  = '0;
                    cnt_d  = '0;
                    if (sel_b_c == '0) begin
                        // Keep the raw dividend: it is the dbz remainder
                        dbz_d   = 1'b1;
                        dvd_d   = sel_a_c;
                        state_d = FIX;
                    end else begin
                        dbz_d   = 1'b0;
                        dvd_d   = mag_a_c;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                rem_d = qbit_c ? diff_c[WID-1:0] : rem_sh_c[WID-1:0];
                dvd_d = {dvd_q[WID-2:0], qbit_c};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d     = IDLE;
                done_v_d    = 1'b1;
                done_src_d  = src_q;
                done_rndx_d = rndx_q;
                done_dbz_d  = dbz_q;
                if (dbz_q) begin
                    done_quo_d = '1;
                    done_rem_d = dvd_q;
                end else begin
                    done_quo_d = quo_fix_c;
                    done_rem_d = rem_fix_c;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush kills any op, including one on its result edge
        if (bus.flush) begin
            state_d     = IDLE;
            done_v_d    = 1'b0;
            done_src_d  = done_src_q;
            done_rndx_d = done_rndx_q;
            done_quo_d  = done_quo_q;
            done_rem_d  = done_rem_q;
            done_dbz_d  = done_dbz_q;
        end
    end

    // FSM state and arbitration pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
        end
    end

    // Operation context and iteration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            src_q  <= 1'b0;
            rndx_q <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            dbz_q  <= 1'b0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            src_q  <= src_d;
            rndx_q <= rndx_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            dbz_q  <= dbz_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            rem_q  <= rem_d;
        end
    end

    // Result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_v_q    <= 1'b0;
            done_src_q  <= 1'b0;
            done_rndx_q <= '0;
            done_quo_q  <= '0;
            done_rem_q  <= '0;
            done_dbz_q  <= 1'b0;
        end else begin
            done_v_q    <= done_v_d;
            done_src_q  <= done_src_d;
            done_rndx_q <= done_rndx_d;
            done_quo_q  <= done_quo_d;
            done_rem_q  <= done_rem_d;
            done_dbz_q  <= done_dbz_d;
        end
    end

    assign bus.gnt0      = gnt0_c;
    assign bus.gnt1      = gnt1_c;
    assign bus.busy      = ~idle_c;
    assign bus.done_v    = done_v_q;
    assign bus.done_src  = done_src_q;
    assign bus.done_rndx = done_rndx_q;
    assign bus.done_q    = done_quo_q;
    assign bus.done_r    = done_rem_q;
    assign bus.done_dbz  = done_dbz_q;
endmodule

// File: tb/tb_qupls_div_arbiter.sv
// Bench for the shared divider: directed vectors, random ops against an
// arithmetic reference, arbitration order, flush and mid-op reset.
module tb_qupls_div_arbiter;
    localparam int unsigned WID      = 8;
    localparam int unsigned RNDX_W   = 5;
    localparam int          DIV_LAT  = WID + 1;
    localparam int          MAX_WAIT = 40;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    qupls_div_arbiter_if #(.WID(WID), .RNDX_W(RNDX_W)) bus ();

    qupls_div_arbiter #(.WID(WID), .RNDX_W(RNDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int                which;
        logic [RNDX_W-1:0] rndx;
        logic [WID-1:0]    a;
        logic [WID-1:0]    b;
        logic              sgn;
        logic [WID-1:0]    q;
        logic [WID-1:0]    r;
        logic              dbz;
        int                lat;
    } vec_t;

    typedef struct {
        logic              src;
        logic [RNDX_W-1:0] rndx;
        logic [WID-1:0]    q;
        logic [WID-1:0]    r;
        logic              dbz;
    } exp_t;

    // Reference: integer division truncating toward zero, dbz gives all-ones / dividend
    function automatic void ref_div(input logic [WID-1:0] a, input logic [WID-1:0] b,
                                    input logic sgn, output logic [WID-1:0] q,
                                    output logic [WID-1:0] r, output logic dbz);
        int sa, sb;
        dbz = 1'b0;
        if (b == '0) begin
            q   = '1;
            r   = a;
            dbz = 1'b1;
        end else if (!sgn) begin
            q = WID'(int'(a) / int'(b));
            r = WID'(int'(a) % int'(b));
        end else begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = WID'(sa / sb);
            r  = WID'(sa % sb);
        end
    endfunction

    function automatic logic [WID-1:0] rand_b();
        if ($urandom_range(0, 5) == 0) return '0;
        return WID'($urandom);
    endfunction

    task automatic clear_inputs();
        bus.req0 = 1'b0; bus.req0_rndx = '0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sgn = 1'b0;
        bus.req1 = 1'b0; bus.req1_rndx = '0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sgn = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic drive_req(input int which, input logic [RNDX_W-1:0] rndx,
                             input logic [WID-1:0] a, input logic [WID-1:0] b, input logic sgn);
        if (which == 0) begin
            bus.req0 = 1'b1; bus.req0_rndx = rndx; bus.req0_a = a; bus.req0_b = b; bus.req0_sgn = sgn;
        end else begin
            bus.req1 = 1'b1; bus.req1_rndx = rndx; bus.req1_a = a; bus.req1_b = b; bus.req1_sgn = sgn;
        end
    endtask

    // Present a request, sample grants before the edge, return #1 after the accept edge
    task automatic start_op(input int which, input logic [RNDX_W-1:0] rndx,
                            input logic [WID-1:0] a, input logic [WID-1:0] b, input logic sgn,
                            output logic g0, output logic g1);
        @(negedge clk);
        drive_req(which, rndx, a, b, sgn);
        #1;
        g0 = bus.gnt0;
        g1 = bus.gnt1;
        @(posedge clk);
        #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    // Count edges from accept until done_v, noting any cycle busy was low meanwhile
    task automatic wait_done(output int lat, output int busy_err, output logic busy_at_done);
        lat      = 0;
        busy_err = 0;
        while (!bus.done_v && lat < MAX_WAIT) begin
            if (!bus.busy) busy_err++;
            @(posedge clk);
            #1;
            lat++;
        end
        busy_at_done = bus.busy;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done_v, bus.done_src, bus.done_dbz, bus.done_rndx, bus.done_q, bus.done_r} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done_v=%b q=%h r=%h rndx=%h expected all zero",
                     bus.busy, bus.done_v, bus.done_q, bus.done_r, bus.done_rndx);
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done_v, bus.gnt0, bus.gnt1, bus.done_q} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: busy=%b done_v=%b gnt=%b%b q=%h expected zero",
                     bus.busy, bus.done_v, bus.gnt0, bus.gnt1, bus.done_q);
        end
    endtask

    task automatic test_directed();
        vec_t v [8];
        logic g0, g1, bad;
        int   lat, busy_err;
        v[0] = '{0, 5'd3,  8'd100, 8'd7,  1'b0, 8'd14,  8'd2,  1'b0, 9};
        v[1] = '{1, 5'd9,  8'hF9,  8'h02, 1'b1, 8'hFD,  8'hFF, 1'b0, 9};
        v[2] = '{0, 5'd17, 8'h80,  8'hFF, 1'b1, 8'h80,  8'h00, 1'b0, 9};
        v[3] = '{1, 5'd30, 8'h55,  8'h00, 1'b0, 8'hFF,  8'h55, 1'b1, 1};
        v[4] = '{0, 5'd1,  8'h07,  8'hFE, 1'b1, 8'hFD,  8'h01, 1'b0, 9};
        v[5] = '{1, 5'd2,  8'hF9,  8'hFE, 1'b1, 8'h03,  8'hFF, 1'b0, 9};
        v[6] = '{0, 5'd4,  8'hFF,  8'h01, 1'b0, 8'hFF,  8'h00, 1'b0, 9};
        v[7] = '{1, 5'd5,  8'h80,  8'h00, 1'b1, 8'hFF,  8'h80, 1'b1, 1};
        foreach (v[i]) begin
            start_op(v[i].which, v[i].rndx, v[i].a, v[i].b, v[i].sgn, g0, g1);
            wait_done(lat, busy_err, bad);
            checks++;
            if ({g0, g1} !== ((v[i].which == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL dir%0d_gnt: got %b%b for requester %0d", i, g0, g1, v[i].which);
            end
            checks++;
            if (lat !== v[i].lat) begin
                errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, v[i].lat);
            end
            checks++;
            if (busy_err != 0 || bad !== 1'b0) begin
                errors++; $display("FAIL dir%0d_busy: low %0d cycles in op, at done %b expected 0", i, busy_err, bad);
            end
            checks++;
            if ({bus.done_q, bus.done_r, bus.done_dbz} !== {v[i].q, v[i].r, v[i].dbz}) begin
                errors++; $display("FAIL dir%0d_result: q=%h r=%h dbz=%b expected q=%h r=%h dbz=%b",
                                   i, bus.done_q, bus.done_r, bus.done_dbz, v[i].q, v[i].r, v[i].dbz);
            end
            checks++;
            if ({bus.done_src, bus.done_rndx} !== {1'(v[i].which), v[i].rndx}) begin
                errors++; $display("FAIL dir%0d_tag: src=%b rndx=%0d expected src=%0d rndx=%0d",
                                   i, bus.done_src, bus.done_rndx, v[i].which, v[i].rndx);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.done_v !== 1'b0 || bus.done_q !== v[i].q || bus.done_rndx !== v[i].rndx) begin
                errors++; $display("FAIL dir%0d_hold: done_v=%b q=%h rndx=%0d expected 0/%h/%0d",
                                   i, bus.done_v, bus.done_q, bus.done_rndx, v[i].q, v[i].rndx);
            end
        end
    endtask

    task automatic test_random();
        logic [RNDX_W-1:0] rndx;
        logic [WID-1:0]    a, b, eq, er;
        logic              sgn, edbz, g0, g1, bad;
        int                which, lat, busy_err, elat;
        for (int n = 0; n < 24; n++) begin
            which = int'($urandom_range(0, 1));
            rndx  = RNDX_W'($urandom);
            a     = WID'($urandom);
            b     = rand_b();
            sgn   = 1'($urandom_range(0, 1));
            ref_div(a, b, sgn, eq, er, edbz);
            elat  = edbz ? 1 : DIV_LAT;
            start_op(which, rndx, a, b, sgn, g0, g1);
            wait_done(lat, busy_err, bad);
            checks++;
            if ({g0, g1} !== ((which == 0) ? 2'b10 : 2'b01) || lat !== elat) begin
                errors++; $display("FAIL rnd%0d_gnt_lat: gnt=%b%b lat=%0d expected req%0d lat=%0d",
                                   n, g0, g1, lat, which, elat);
            end
            checks++;
            if ({bus.done_q, bus.done_r, bus.done_dbz, bus.done_src, bus.done_rndx} !==
                {eq, er, edbz, 1'(which), rndx}) begin
                errors++; $display("FAIL rnd%0d_result: a=%h b=%h sgn=%b got q=%h r=%h dbz=%b src=%b rndx=%0d expected q=%h r=%h dbz=%b src=%0d rndx=%0d",
                                   n, a, b, sgn, bus.done_q, bus.done_r, bus.done_dbz, bus.done_src,
                                   bus.done_rndx, eq, er, edbz, which, rndx);
            end
        end
    endtask

    // Both requesters held high from reset; grants must alternate and chain off done_v
    task automatic test_arbitration();
        exp_t e;
        exp_t pend [$];
        logic g0, g1, dv, chg0, chg1;
        int   exp_rr, grants, cycles, winner;
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n  = 1'b1;
        exp_rr = 0;
        grants = 0;
        cycles = 0;
        chg0   = 1'b1;
        chg1   = 1'b1;
        while (grants < 6 && cycles < 300) begin
            @(negedge clk);
            cycles++;
            if (chg0) begin
                drive_req(0, RNDX_W'(grants), WID'($urandom), rand_b(), 1'($urandom_range(0, 1)));
                chg0 = 1'b0;
            end
            if (chg1) begin
                drive_req(1, RNDX_W'(grants + 16), WID'($urandom), rand_b(), 1'($urandom_range(0, 1)));
                chg1 = 1'b0;
            end
            #1;
            g0 = bus.gnt0;
            g1 = bus.gnt1;
            dv = bus.done_v;
            if (dv) begin
                checks++;
                if (pend.size() == 0) begin
                    errors++; $display("FAIL arb_spurious_done: done_v=1 expected no result pending");
                end else begin
                    e = pend.pop_front();
                    if ({bus.done_src, bus.done_rndx, bus.done_q, bus.done_r, bus.done_dbz} !==
                        {e.src, e.rndx, e.q, e.r, e.dbz}) begin
                        errors++; $display("FAIL arb_result: src=%b rndx=%0d q=%h r=%h dbz=%b expected src=%b rndx=%0d q=%h r=%h dbz=%b",
                                           bus.done_src, bus.done_rndx, bus.done_q, bus.done_r, bus.done_dbz,
                                           e.src, e.rndx, e.q, e.r, e.dbz);
                    end
                end
            end
            if (g0 || g1) begin
                checks++;
                if ({g0, g1} !== ((exp_rr == 0) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL arb_order: grant %0d got %b%b expected requester %0d", grants, g0, g1, exp_rr);
                end
                if (grants > 0) begin
                    checks++;
                    if (dv !== 1'b1) begin
                        errors++; $display("FAIL arb_back_to_back: grant %0d with done_v=%b expected 1", grants, dv);
                    end
                end
                winner = g1 ? 1 : 0;
                e.src  = 1'(winner);
                if (winner == 0) begin
                    e.rndx = bus.req0_rndx;
                    ref_div(bus.req0_a, bus.req0_b, bus.req0_sgn, e.q, e.r, e.dbz);
                    chg0 = 1'b1;
                end else begin
                    e.rndx = bus.req1_rndx;
                    ref_div(bus.req1_a, bus.req1_b, bus.req1_sgn, e.q, e.r, e.dbz);
                    chg1 = 1'b1;
                end
                pend.push_back(e);
                exp_rr = 1 - winner;
                grants++;
            end
        end
        checks++;
        if (grants < 6) begin
            errors++; $display("FAIL arb_timeout: %0d grants in %0d cycles expected 6", grants, cycles);
        end
        @(posedge clk);
        #1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        for (int c = 0; c < MAX_WAIT && pend.size() != 0; c++) begin
            @(negedge clk);
            if (bus.done_v) begin
                e = pend.pop_front();
                checks++;
                if ({bus.done_src, bus.done_rndx, bus.done_q, bus.done_r, bus.done_dbz} !==
                    {e.src, e.rndx, e.q, e.r, e.dbz}) begin
                    errors++; $display("FAIL arb_last_result: q=%h r=%h expected q=%h r=%h",
                                       bus.done_q, bus.done_r, e.q, e.r);
                end
            end
        end
        checks++;
        if (pend.size() != 0) begin
            errors++; $display("FAIL arb_drain: %0d results missing expected 0", pend.size());
        end
    endtask

    task automatic test_flush();
        logic [WID-1:0] a, b, eq, er, prev_q;
        logic           sgn, edbz, g0, g1, bad;
        int             lat, busy_err, seen;
        // Flush four cycles after accept
        start_op(0, 5'd7, 8'd200, 8'd3, 1'b0, g0, g1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        drive_req(1, 5'd11, 8'd9, 8'd2, 1'b0);
        #1;
        checks++;
        if (bus.gnt1 !== 1'b0) begin
            errors++; $display("FAIL flush_busy_gnt: gnt1=%b expected 0", bus.gnt1);
        end
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.req1  = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.done_v !== 1'b0) begin
            errors++; $display("FAIL flush_idle: busy=%b done_v=%b expected 0/0", bus.busy, bus.done_v);
        end
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus.done_v) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL flush_no_done: done_v seen %0d times expected 0", seen);
        end
        // Next op after flush completes normally
        a   = WID'($urandom);
        b   = WID'($urandom_range(1, 255));
        sgn = 1'($urandom_range(0, 1));
        ref_div(a, b, sgn, eq, er, edbz);
        start_op(1, 5'd12, a, b, sgn, g0, g1);
        wait_done(lat, busy_err, bad);
        checks++;
        if (g1 !== 1'b1 || lat !== DIV_LAT || {bus.done_q, bus.done_r, bus.done_src} !== {eq, er, 1'b1}) begin
            errors++; $display("FAIL flush_next_op: gnt1=%b lat=%0d q=%h r=%h src=%b expected 1/%0d/%h/%h/1",
                               g1, lat, bus.done_q, bus.done_r, bus.done_src, DIV_LAT, eq, er);
        end
        prev_q = eq;
        // Flush while idle blocks a grant
        @(negedge clk);
        bus.flush = 1'b1;
        drive_req(0, 5'd13, 8'd50, 8'd5, 1'b0);
        #1;
        checks++;
        if (bus.gnt0 !== 1'b0) begin
            errors++; $display("FAIL flush_idle_gnt: gnt0=%b expected 0", bus.gnt0);
        end
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.req0  = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++; $display("FAIL flush_idle_accept: busy=%b expected 0", bus.busy);
        end
        // Flush landing on the result edge suppresses the result
        start_op(0, 5'd14, 8'd77, 8'd5, 1'b0, g0, g1);
        repeat (WID) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        checks++;
        if (bus.done_v !== 1'b0 || bus.busy !== 1'b0 || bus.done_q !== prev_q) begin
            errors++; $display("FAIL flush_fix: done_v=%b busy=%b q=%h expected 0/0/%h",
                               bus.done_v, bus.busy, bus.done_q, prev_q);
        end
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.done_v) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL flush_fix_late: done_v seen %0d times expected 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        logic g0, g1;
        int   seen;
        start_op(1, 5'd21, 8'hC3, 8'd6, 1'b1, g0, g1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done_v, bus.done_src, bus.done_dbz, bus.done_rndx, bus.done_q, bus.done_r} !== '0) begin
            errors++; $display("FAIL reset_mid_outputs: busy=%b q=%h r=%h rndx=%0d src=%b expected all zero",
                               bus.busy, bus.done_q, bus.done_r, bus.done_rndx, bus.done_src);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done_v || bus.busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL reset_mid_no_done: activity in %0d cycles expected 0", seen);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_directed();
        test_random();
        test_arbitration();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/qupls_div_arbiter.md
Name: qupls_div_arbiter

Overview:
- Shares one iterative radix-2 integer divider between the two ALU issue slots (requester 0 = ALU0, requester 1 = ALU1).
- Arbitrates divide requests round-robin and runs the long-latency division.
- Returns quotient and remainder tagged with the ROB index.
- Drives a busy flag that the scheduler folds into its ALU idle inputs, so no further divide issues while the unit is occupied.

Parameters:
- WID, 64: operand/result width in bits; iteration count equals WID.
- RNDX_W, 5: ROB index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  ALU0 divide request
- req0_rndx  in  RNDX_W  ROB index of ALU0 request
- req0_a  in  WID  dividend
- req0_b  in  WID  divisor
- req0_sgn  in  1  signed divide
- req1, req1_rndx, req1_a, req1_b, req1_sgn  in  same widths  ALU1 request
- flush  in  1  pipeline flush; kills in-flight op
- gnt0  out  1  request 0 accepted at this edge
- gnt1  out  1  request 1 accepted at this edge
- busy  out  1  divider occupied
- done_v  out  1  result valid, one-cycle pulse
- done_src  out  1  requester that owned the op
- done_rndx  out  RNDX_W  ROB index of result
- done_q  out  WID  quotient
- done_r  out  WID  remainder
- done_dbz  out  1  divide-by-zero flag

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, rr=0, busy=0, done_v=0, done_src=0, done_dbz=0.
  - done_rndx, done_q and done_r are all zero.
  - Iteration counter is zero.
  - Reset mid-operation abandons the op with no done_v.
- States:
  - IDLE: accept a request.
  - DIV: one quotient bit per cycle.
  - FIX: sign correction and output register.
- gnt is combinational: gntN = reqN & state==IDLE & !flush & arbitration win.
  - Only one request: it wins.
  - Both requests: requester rr wins.
  - After any grant, rr = the non-granted index.
  - Requester holds reqN/operands until gntN is seen high; the op is captured at that edge.
- Accept edge (E0):
  - Latch rndx, src and sgn.
  - Form magnitudes |a|, |b| when sgn, else raw.
  - Record neg_q = sgn&(a[msb]^b[msb]) and neg_r = sgn&a[msb].
  - If b==0: go to FIX with dbz=1. Otherwise go to DIV with count=0.
- DIV:
  - Restoring step on a WID+1-bit partial remainder.
  - Shift in the next dividend bit; subtract the divisor if no borrow; shift in the quotient bit.
  - count increments; at count==WID-1 go to FIX. DIV occupies exactly WID edges.
- FIX edge (one edge):
  - Normal result: done_q = neg_q ? -q : q; done_r = neg_r ? -r : r.
  - dbz result: done_q = all ones, done_r = original dividend, done_dbz=1.
  - Load done_rndx and done_src, set done_v=1, go to IDLE.
- done_v clears on the next edge unless a new FIX edge occurs. done_q, done_r, done_rndx and done_src hold until the next FIX.
- Latency from accept edge to done_v high:
  - Normal: WID+1 cycles.
  - dbz: 1 cycle.
- Signed overflow (min / -1): q = min, r = 0, falling out of magnitude arithmetic. No special flag.
- Division truncates toward zero; the remainder takes the dividend's sign.
- busy = (state != IDLE). busy is low in the cycle done_v is high, so a new grant can occur that cycle (back-to-back).
- flush:
  - Forces state=IDLE at the next edge with no done_v and no gnt that cycle; rr is unchanged.
  - Flush coincident with the FIX edge: the FIX result is suppressed (done_v stays 0).
- Request arriving while busy: no grant. The requester waits; the scheduler normally prevents this via busy.

Test Plan (WID=8, RNDX_W=5):
- Unsigned div, single requester:
  - Stimulus: req0, rndx=3, a=100, b=7, sgn=0.
  - Response: gnt0 at E0; done_v exactly 9 cycles later; q=14, r=2, src=0, rndx=3, dbz=0; busy high cycles 1..8.
- Signed div, requester 1:
  - Stimulus: req1, a=-7 (0xF9), b=2, sgn=1.
  - Response: q=0xFD (-3), r=0xFF (-1), src=1.
- Signed overflow:
  - Stimulus: a=0x80, b=0xFF, sgn=1.
  - Response: q=0x80, r=0x00.
- Divide by zero:
  - Stimulus: a=0x55, b=0.
  - Response: done_v 1 cycle after accept; q=0xFF, r=0x55, dbz=1.
- Arbitration:
  - Stimulus: req0 and req1 held high continuously from reset.
  - Response: grants 0,1,0,1 on successive ops; each new gnt occurs in the same cycle as the prior done_v.
- Flush:
  - Stimulus: flush asserted 4 cycles after accept.
  - Response: busy drops the next cycle; no done_v ever; a following req1 is granted normally and produces a correct result.
- Reset:
  - Stimulus: rst_n pulsed mid-DIV.
  - Response: all outputs zero immediately; no done_v.
